// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and Baugh-Wooley helpers for the pipelined array multiplier
package mult_pkg;

    localparam int MAX_W = 16;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Payload carried by every pipeline stage; fields are sized for the
    // widest legal operand and narrower instances leave the top bits zero.
    typedef struct packed {
        logic               valid;
        logic               mode;
        logic [MAX_W-1:0]   a;
        logic [MAX_W-1:0]   b;
        logic [2*MAX_W-1:0] sum;
    } stage_payload_t;

    // Partial-product row idx, already shifted into place. In signed mode the
    // cross terms involving exactly one operand MSB are inverted (Baugh-Wooley).
    function automatic logic [2*MAX_W-1:0] pp_row(
        input logic [MAX_W-1:0] a,
        input logic             b_bit,
        input int               idx,
        input logic             mode,
        input int               width
    );
        logic [2*MAX_W-1:0] row;
        row = '0;
        for (int j = 0; j < MAX_W; j++) begin
            if (j < width) begin
                row[j] = a[j] & b_bit;
                if (mode == MODE_SIGNED && ((idx == width - 1) != (j == width - 1))) begin
                    row[j] = ~row[j];
                end
            end
        end
        return row << idx;
    endfunction

    // Correction constant 2^width + 2^(2*width-1) that completes the signed product.
    function automatic logic [2*MAX_W-1:0] bw_const(input int width);
        logic [2*MAX_W:0] c;
        c = (33'd1 << width) + (33'd1 << (2 * width - 1));
        return c[2*MAX_W-1:0];
    endfunction

    // Mask that truncates the running sum to 2*width bits.
    function automatic logic [2*MAX_W-1:0] sum_mask(input int width);
        logic [2*MAX_W:0] m;
        m = (33'd1 << (2 * width)) - 33'd1;
        return m[2*MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// rtl/mult_pp_stage.sv - combinational adder of ROWS partial-product rows for one pipeline stage
module mult_pp_stage
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ROWS      = 2,
    parameter int STAGE_IDX = 0
) (
    input  stage_payload_t pin,
    output stage_payload_t pout
);

    // Add this stage's rows (plus the signed correction constant in stage 0).
    always_comb begin
        logic [2*MAX_W-1:0] acc;
        logic               b_bit;
        pout  = pin;
        acc   = pin.sum;
        b_bit = 1'b0;
        if (STAGE_IDX == 0 && pin.mode == MODE_SIGNED) begin
            acc = acc + bw_const(WIDTH);
        end
        for (int r = 0; r < ROWS; r++) begin
            b_bit = |(pin.b & (16'd1 << (STAGE_IDX * ROWS + r)));
            acc   = acc + pp_row(pin.a, b_bit, STAGE_IDX * ROWS + r, pin.mode, WIDTH);
        end
        pout.sum = acc & sum_mask(WIDTH);
    end

endmodule

// File: rtl/pipelined_array_multiplier.sv
// rtl/pipelined_array_multiplier.sv - pipelined WIDTHxWIDTH signed/unsigned multiplier with valid/ready
module pipelined_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int ROWS = WIDTH / STAGES;

    stage_payload_t             stage_q [STAGES];
    stage_payload_t             stage_d [STAGES];
    stage_payload_t             in_beat;
    logic                       out_valid_q;
    logic [2*WIDTH-1:0]         p_q;
    logic                       stall;

    // A held product blocks the whole pipe; in_ready never looks at in_valid.
    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign p         = p_q;

    // Zero-extend the operands into the shared payload layout; sum starts at 0.
    always_comb begin
        in_beat              = '0;
        in_beat.valid        = in_valid;
        in_beat.mode         = signed_mode;
        in_beat.a[WIDTH-1:0] = a;
        in_beat.b[WIDTH-1:0] = b;
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            mult_pp_stage #(
                .WIDTH     (WIDTH),
                .ROWS      (ROWS),
                .STAGE_IDX (k)
            ) u_stage (
                .pin  (stage_q[k]),
                .pout (stage_d[k])
            );
        end
    endgenerate

    // Stage registers and output register advance together unless stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else if (!stall) begin
            stage_q[0] <= in_beat;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k-1];
            end
            out_valid_q <= stage_d[STAGES-1].valid;
            if (stage_d[STAGES-1].valid) begin
                p_q <= stage_d[STAGES-1].sum[2*WIDTH-1:0];
            end
        end
    end

    // busy covers the stage registers only, not the output register.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy = busy | stage_q[k].valid;
        end
    end

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// tb/tb_pipelined_array_multiplier.sv - scoreboard bench for pipelined_array_multiplier
module tb_pipelined_array_multiplier;

    typedef struct {
        logic [31:0] p;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sw_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        signed_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] p;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_array_multiplier #(.WIDTH(8), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic m, input int w);
        longint sx, sy, pr;
        logic [63:0] t;
        sx = longint'(x);
        sy = longint'(y);
        if (m) begin
            sx = (sx <<< (64 - w)) >>> (64 - w);
            sy = (sy <<< (64 - w)) >>> (64 - w);
        end
        pr = sx * sy;
        t = pr;
        t = t & ((64'd1 << (2 * w)) - 64'd1);
        return t[31:0];
    endfunction

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic m,
                        input logic [15:0] pe, input bit push, input bit lat);
        in_valid = 1'b1;
        a = x;
        b = y;
        signed_mode = m;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                if (push) q.push_back('{{16'h0, pe}, cyc + 1, lat});
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        fail_now("send_accept");
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) fail_now("drain");
    endtask

    // Monitor: every output transfer is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none", p);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("product", {48'h0, p}, {32'h0, e.p});
                if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd4);
            end
        end
    end

    localparam int SWW[4] = '{4, 4, 8, 16};
    localparam int SWS[4] = '{1, 2, 8, 4};

    generate
        for (genvar g = 0; g < 4; g++) begin : sw
            localparam int W = SWW[g];
            localparam int S = SWS[g];
            logic [W-1:0]   xa = '0;
            logic [W-1:0]   xb = '0;
            logic           xm = 1'b0;
            logic           xv = 1'b0;
            logic           xir, xov, xbusy;
            logic [2*W-1:0] xp;
            bit             done = 1'b0;
            exp_t           sq[$];

            pipelined_array_multiplier #(.WIDTH(W), .STAGES(S)) dut_sw (
                .clk(clk), .rst_n(sw_rst_n), .in_valid(xv), .in_ready(xir),
                .a(xa), .b(xb), .signed_mode(xm), .out_valid(xov),
                .out_ready(1'b1), .p(xp), .busy(xbusy)
            );

            initial begin
                logic [15:0] rx, ry;
                logic        rm;
                int          n;
                n = (W == 4) ? 512 : 150;
                wait (sw_rst_n === 1'b1);
                @(negedge clk);
                for (int i = 0; i < n; i++) begin
                    if (W == 4) begin
                        rx = 16'(i % 16);
                        ry = 16'((i / 16) % 16);
                        rm = (i / 256) != 0;
                    end else begin
                        rx = 16'($urandom) & 16'((32'd1 << W) - 1);
                        ry = 16'($urandom) & 16'((32'd1 << W) - 1);
                        rm = i[0];
                    end
                    xv = 1'b1;
                    xa = rx[W-1:0];
                    xb = ry[W-1:0];
                    xm = rm;
                    sq.push_back('{model(rx, ry, rm, W), cyc + 1, 1'b1});
                    @(negedge clk);
                end
                xv = 1'b0;
                for (int i = 0; i < 100 && sq.size() != 0; i++) @(negedge clk);
                if (sq.size() != 0) fail_now("sweep_drain");
                done = 1'b1;
            end

            always @(negedge clk) begin
                if (sw_rst_n && xov) begin
                    if (sq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sweep_unexpected w=%0d s=%0d actual=%0h required=none", W, S, xp);
                    end else begin
                        exp_t e;
                        e = sq.pop_front();
                        chk($sformatf("sweep_product_w%0d_s%0d", W, S), 64'(xp), {32'h0, e.p});
                        chk($sformatf("sweep_latency_w%0d_s%0d", W, S), 64'(cyc - e.acc), 64'(S));
                    end
                end
            end
        end
    endgenerate

    initial begin
        logic [7:0] rx, ry;
        logic       rm;
        int         last;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_p", 64'(p), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        sw_rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Single beats and signed corners
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 1'b1); drain();
        send(8'hFF, 8'h02, 1'b0, 16'h01FE, 1'b1, 1'b1); drain();
        send(8'hFF, 8'h02, 1'b1, 16'hFFFE, 1'b1, 1'b1); drain();
        send(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, 1'b1); drain();
        send(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1, 1'b1); drain();
        send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1, 1'b1); drain();
        send(8'h00, 8'h80, 1'b1, 16'h0000, 1'b1, 1'b1); drain();

        // Back-to-back stream, alternating mode
        last = 0;
        for (int i = 0; i < 100; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rm = i[0];
            last = cyc + 1;
            send(rx, ry, rm, model({8'h0, rx}, {8'h0, ry}, rm, 8), 1'b1, 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_drop", 64'(busy), 64'd1);
        chk("busy_drop_cycle", 64'(cyc - last), 64'd3);
        @(negedge clk);
        chk("busy_after_drop", 64'(busy), 64'd0);
        drain();

        // Backpressure with a full pipe
        out_ready = 1'b0;
        send(8'h03, 8'h05, 1'b0, 16'h000F, 1'b1, 1'b0);
        send(8'h10, 8'h10, 1'b0, 16'h0100, 1'b1, 1'b0);
        send(8'hFE, 8'h03, 1'b1, 16'hFFFA, 1'b1, 1'b0);
        send(8'hAA, 8'h02, 1'b0, 16'h0154, 1'b1, 1'b0);
        send(8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_p", 64'(p), 64'h000F);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight
        send(8'h11, 8'h22, 1'b0, 16'h0000, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b1, 16'h0000, 1'b0, 1'b0);
        send(8'h55, 8'h66, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("busy_in_flight", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_p", 64'(p), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(8'h0C, 8'h0D, 1'b0, 16'h009C, 1'b1, 1'b1);
        drain();

        // Wait for the parameter sweep instances
        for (int i = 0; i < 5000; i++) begin
            if (sw[0].done && sw[1].done && sw[2].done && sw[3].done) break;
            @(negedge clk);
        end
        if (!(sw[0].done && sw[1].done && sw[2].done && sw[3].done)) fail_now("sweep_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_array_multiplier.md
Name: pipelined_array_multiplier

Overview:
- Parametrised, pipelined successor to the 4x4 combinational array multiplier.
- Computes a WIDTH x WIDTH product in STAGES register stages. Mode is per transaction: unsigned or two's-complement signed.
- Valid/ready handshake on both sides, with backpressure. Sits between a register/IO front end and downstream result consumers in the user project.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH. Legal: 2..16.
- STAGES, 4, number of pipeline register stages. Must divide WIDTH; each stage adds WIDTH/STAGES partial-product rows.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- signed_mode  in  1  1 = both operands two's-complement, 0 = both unsigned; sampled with a/b
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  2*WIDTH  product
- busy  out  1  any stage holds a valid beat

Behaviour:
- Reset (rst_n=0, async assert, sync release):
  - all stage valid bits = 0, out_valid = 0, p = 0, busy = 0.
  - in_ready = 1 on the first edge after release.
  - Reset mid-operation discards all in-flight beats; no product is emitted for them.
- Accept: a beat transfers on a rising edge with in_valid && in_ready. a, b and signed_mode are captured together. Mode travels with its data through every stage, so mixed-mode back-to-back beats are legal.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall. This is combinational, with no path from in_valid.
  - On stall, every stage register, including p, holds.
  - With no stall the pipeline advances every cycle; bubbles (invalid stages) advance too.
- Latency: beat accepted at edge t gives out_valid=1 after edge t+STAGES, provided no stall occurred in between. Each stall cycle adds one cycle. Throughput is 1 product/cycle.
- Output transfer: on an edge with out_valid && out_ready, the beat leaves. out_valid then reflects the next stage-(STAGES-1) beat or drops to 0. p holds its last value when out_valid=0.
- Arithmetic:
  - Stage k (0..STAGES-1) adds rows k*R..k*R+R-1 to the running sum, where R = WIDTH/STAGES. Row i = (a AND b[i]) << i.
  - Unsigned: exact 2*WIDTH-bit product.
  - Signed: Baugh-Wooley. Invert the MSB cross terms, invert the MSB row except its top bit, and add the constant 1<<WIDTH + 1<<(2*WIDTH-1) in stage 0. The result is the exact two's-complement 2*WIDTH-bit product, with no overflow for any operand pair, including most-negative x most-negative.
  - The running sum is 2*WIDTH bits wide and is truncated modulo 2^(2*WIDTH) at every stage.
- Simultaneous events: accept and output transfer in the same cycle is legal and is the full-throughput steady state.
- busy = OR of all stage valid bits.

Decomposition:
- Package mult_pkg:
  - mode encoding (MODE_UNSIGNED=0, MODE_SIGNED=1)
  - function pp_row(a, bit, idx, mode, width) giving the Baugh-Wooley-adjusted row
  - function bw_const(width)
  - stage payload struct {valid, mode, a, b, sum}
- One sub-module, mult_pp_stage: a combinational R-row adder from payload-in to payload-out, instantiated STAGES times via generate. The top level owns the registers, the global stall enable and the handshake.

Test Plan:
- Reset then single beats, WIDTH=8, STAGES=4:
  - unsigned 0xFF x 0xFF -> p=0xFE01, out_valid exactly 4 cycles after accept
  - unsigned 0xFF x 0x02 -> 0x01FE
  - signed 0xFF x 0x02 -> 0xFFFE
- Signed corners:
  - 0x80 x 0x80 -> 0x4000
  - 0x80 x 0x7F -> 0xC080
  - 0xFF x 0xFF -> 0x0001
  - 0x00 x 0x80 -> 0x0000
- Back-to-back stream: 100 random beats, in_valid=1 and out_ready=1, alternating signed_mode -> one result per cycle, in order, all matching the model; busy drops 4 cycles after the last accept.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, p and out_valid stable. Release -> no loss or duplication, order preserved.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0 and p=0 immediately (async). After release, no stale product appears and the next beat has normal 4-cycle latency.
- Parameter sweep: (WIDTH,STAGES) = (4,1), (4,2), (8,8), (16,4) -> exhaustive for WIDTH=4, random otherwise; latency = STAGES in every case.
